mem_stage: RTL and testbench

MEM stage of the five-stage MIPS pipeline, directly downstream of EX. Captures the EX results (ALU output, store operand, memory and write-back controls) into an internal EX/MEM register. Runs the data-memory request/grant/response handshake with byte-lane steering for byte, halfword and word accesses. Produces the MEM/WB register contents and a stall back to the upstream stages.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_align.sv | 28 ++
 rtl/mem_stage.sv | 92 +++++++++
 tb/tb_mem_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: size codes, FSM states and pipeline register bundles for the MEM stage
package mem_pkg;
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu;
        logic [31:0] regb;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  size;
        logic        sign;
        logic        reg_write;
        logic [4:0]  rd;
    } exmem_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd;
        logic [31:0] data;
    } memwb_t;
endpackage

// File: rtl/mem_align.sv
// mem_align: byte-lane steering for stores, load extract/extend and misalign detect
module mem_align (
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_sign,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);
    import mem_pkg::*;

    logic [31:0] w_shift;

    // Size code 11 falls through every compare and behaves as a word access
    always_comb begin
        w_shift    = i_rdata >> {i_addr, 3'b000};
        o_misalign = (i_size == MEM_HALF) ? i_addr[0] : (i_size != MEM_BYTE) && (i_addr != 2'b00);
        o_be       = (i_size == MEM_BYTE) ? 4'b0001 << i_addr :
                     (i_size == MEM_HALF) ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        o_wdata    = (i_size == MEM_BYTE) ? {4{i_wdata[7:0]}} :
                     (i_size == MEM_HALF) ? {2{i_wdata[15:0]}} : i_wdata;
        o_rdata    = (i_size == MEM_BYTE) ? {{24{i_sign & w_shift[7]}}, w_shift[7:0]} :
                     (i_size == MEM_HALF) ? {{16{i_sign & w_shift[15]}}, w_shift[15:0]} : w_shift;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: EX/MEM register, data-memory handshake FSM and MEM/WB register
module mem_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [31:0]       ex_ALUout,
    input  logic [31:0]       ex_RegB,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic [1:0]        ex_MemSize,
    input  logic              ex_MemSign,
    input  logic              ex_RegWrite,
    input  logic [4:0]        ex_rd,
    input  logic              flush,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    output logic              wb_valid,
    output logic              wb_RegWrite,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misalign_exc
);
    import mem_pkg::*;

    exmem_t      r_ex;
    memwb_t      r_wb;
    mem_state_t  r_state, w_state, w_next;
    logic        w_mem, w_mis, w_ok, w_store_done, w_load_done, w_done;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_rext;

    mem_align u_align (
        .i_addr    (r_ex.alu[1:0]),
        .i_size    (r_ex.size),
        .i_sign    (r_ex.sign),
        .i_wdata   (r_ex.regb),
        .i_rdata   (dmem_rdata),
        .o_be      (w_be),
        .o_wdata   (w_wdata),
        .o_rdata   (w_rext),
        .o_misalign(w_mis)
    );

    // A fresh aligned memory op in the register is already in ACCESS, so the request goes out combinationally
    always_comb begin
        w_mem        = r_ex.valid && (r_ex.mem_read || r_ex.mem_write);
        w_ok         = w_mem && !w_mis;
        w_state      = (r_state == ST_IDLE && w_ok) ? ST_ACCESS : r_state;
        w_store_done = (w_state == ST_ACCESS) && dmem_gnt && r_ex.mem_write;
        w_load_done  = (w_state == ST_RESP) && dmem_rvalid;
        w_done       = r_ex.valid && (!w_ok || w_store_done || w_load_done);
        w_next       = (w_state == ST_ACCESS && dmem_gnt) ? (r_ex.mem_write ? ST_IDLE : ST_RESP) :
                       w_load_done ? ST_IDLE : w_state;
        stall_out    = w_ok && !w_done;
        misalign_exc = w_mem && w_mis;
        dmem_req     = (w_state == ST_ACCESS);
        dmem_we      = dmem_req && r_ex.mem_write;
        dmem_addr    = dmem_req ? {r_ex.alu[ADDR_W-1:2], 2'b00} : '0;
        dmem_be      = dmem_req ? w_be : 4'b0000;
        dmem_wdata   = dmem_we ? w_wdata : 32'd0;
        wb_valid     = r_wb.valid;
        wb_RegWrite  = r_wb.reg_write;
        wb_rd        = r_wb.rd;
        wb_data      = r_wb.data;
    end

    // FSM state register; reset abandons any in-flight load so a late rvalid is dropped
    always_ff @(posedge clk) r_state <= !reset ? ST_IDLE : w_next;

    // EX/MEM register: frozen while stalled (flush ignored then), bubble on flush or invalid EX
    always_ff @(posedge clk) begin
        if (!reset) r_ex <= '0;
        else if (!stall_out) r_ex <= (ex_valid && !flush) ?
            '{1'b1, ex_ALUout, ex_RegB, ex_MemRead, ex_MemWrite, ex_MemSize, ex_MemSign, ex_RegWrite, ex_rd} : '0;
    end

    // MEM/WB register: one valid cycle per retired op; stores and misaligned ops never write rd
    always_ff @(posedge clk) begin
        if (!reset || !w_done) r_wb <= '0;
        else r_wb <= '{1'b1, r_ex.reg_write && !r_ex.mem_write && !misalign_exc, r_ex.rd,
                       w_load_done ? w_rext : r_ex.alu};
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors with a scoreboard checked by an independent MEM/WB monitor
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        reset, ex_valid, ex_MemRead, ex_MemWrite, ex_MemSign, ex_RegWrite, flush;
    logic [31:0] ex_ALUout, ex_RegB, dmem_rdata;
    logic [1:0]  ex_MemSize;
    logic [4:0]  ex_rd;
    logic        dmem_gnt, dmem_rvalid;
    logic        stall_out, dmem_req, dmem_we, wb_valid, wb_RegWrite, misalign_exc;
    logic [31:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_pass = 0;
    int   n_tot = 0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ALUout(ex_ALUout), .ex_RegB(ex_RegB),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_MemSize(ex_MemSize),
        .ex_MemSign(ex_MemSign), .ex_RegWrite(ex_RegWrite), .ex_rd(ex_rd), .flush(flush),
        .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic mr, input logic mw, input logic [1:0] sz, input logic sg,
                            input logic rw, input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rb);
        ex_valid = 1'b1; ex_MemRead = mr; ex_MemWrite = mw; ex_MemSize = sz; ex_MemSign = sg;
        ex_RegWrite = rw; ex_rd = rd; ex_ALUout = alu; ex_RegB = rb;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0; ex_MemRead = 1'b0; ex_MemWrite = 1'b0;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] res);
        sb.push_back('{1'b1, rd, res});
        drive_ex(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, rd, res, 32'h0);
        step();
    endtask

    // Load: grant in the first cycle after capture, rvalid in the next
    task automatic load_op(input logic [31:0] addr, input logic [1:0] sz, input logic sg, input logic [4:0] rd,
                           input logic [31:0] rdata, input logic [31:0] exp_data, input logic [3:0] exp_be);
        sb.push_back('{1'b1, rd, exp_data});
        drive_ex(1'b1, 1'b0, sz, sg, 1'b1, rd, addr, 32'h0);
        step();
        idle_ex();
        dmem_gnt = 1'b1;
        #2;
        chk("ld_req", 32'(dmem_req), 32'd1);
        chk("ld_we", 32'(dmem_we), 32'd0);
        chk("ld_addr", dmem_addr, {addr[31:2], 2'b00});
        chk("ld_be", 32'(dmem_be), 32'(exp_be));
        chk("ld_stall_gnt", 32'(stall_out), 32'd1);
        step();
        dmem_gnt = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata = rdata;
        #2;
        chk("ld_req_resp", 32'(dmem_req), 32'd0);
        chk("ld_stall_rvalid", 32'(stall_out), 32'd0);
        step();
        dmem_rvalid = 1'b0;
    endtask

    // Store: grant withheld for 'waits' cycles with flush asserted, which must not disturb a stalled op
    task automatic store_op(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data,
                            input logic [4:0] rd, input int waits, input logic [3:0] exp_be, input logic [31:0] exp_wd);
        sb.push_back('{1'b0, rd, addr});
        drive_ex(1'b0, 1'b1, sz, 1'b0, 1'b1, rd, addr, data);
        step();
        idle_ex();
        dmem_gnt = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < waits; i++) begin
            #2;
            chk("st_req_wait", 32'(dmem_req), 32'd1);
            chk("st_we_wait", 32'(dmem_we), 32'd1);
            chk("st_addr_wait", dmem_addr, {addr[31:2], 2'b00});
            chk("st_be_wait", 32'(dmem_be), 32'(exp_be));
            chk("st_wdata_wait", dmem_wdata, exp_wd);
            chk("st_stall_wait", 32'(stall_out), 32'd1);
            step();
        end
        flush = 1'b0;
        dmem_gnt = 1'b1;
        #2;
        chk("st_req_gnt", 32'(dmem_req), 32'd1);
        chk("st_be", 32'(dmem_be), 32'(exp_be));
        chk("st_wdata", dmem_wdata, exp_wd);
        chk("st_stall_gnt", 32'(stall_out), 32'd0);
        step();
        dmem_gnt = 1'b0;
    endtask

    // Monitor: every retirement must match the oldest expected entry
    always @(negedge clk) begin
        if (wb_valid) begin
            if (sb.size() == 0) begin
                n_tot++;
                $display("FAIL wb_unexpected: got retire rd %0d data %h, required no retire", wb_rd, wb_data);
            end else begin
                e = sb.pop_front();
                chk("wb_RegWrite", 32'(wb_RegWrite), 32'(e.rw));
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; flush = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        drive_ex(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd8, 32'h100, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            #2;
            chk("rst_outputs", 32'(|{stall_out, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                                     wb_valid, wb_RegWrite, wb_rd, wb_data, misalign_exc}), 32'd0);
        end
        reset = 1'b1;
        idle_ex();
        step();
        load_op(32'h100, 2'b10, 1'b0, 5'd8, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111);
        load_op(32'h103, 2'b00, 1'b1, 5'd9, 32'h80123456, 32'hFFFFFF80, 4'b1000);
        load_op(32'h103, 2'b00, 1'b0, 5'd10, 32'h80123456, 32'h00000080, 4'b1000);
        load_op(32'h102, 2'b01, 1'b1, 5'd11, 32'h87651234, 32'hFFFF8765, 4'b1100);
        store_op(32'h102, 2'b01, 32'h0000ABCD, 5'd5, 3, 4'b1100, 32'hABCDABCD);
        store_op(32'h101, 2'b00, 32'h12345677, 5'd6, 0, 4'b0010, 32'h77777777);
        // Misaligned word load retires without a request, and the next op follows immediately
        sb.push_back('{1'b0, 5'd12, 32'h101});
        drive_ex(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd12, 32'h101, 32'h0);
        step();
        drive_ex(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd4, 32'h77, 32'h0);
        sb.push_back('{1'b1, 5'd4, 32'h77});
        #2;
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_exc", 32'(misalign_exc), 32'd1);
        chk("mis_stall", 32'(stall_out), 32'd0);
        step();
        idle_ex();
        #2;
        chk("mis_exc_pulse", 32'(misalign_exc), 32'd0);
        step();
        // A flushed op must never retire
        drive_ex(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 5'd20, 32'hBAD, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_ex();
        step();
        // Back-to-back ALU ops at one per cycle
        alu_op(5'd1, 32'h11);
        alu_op(5'd2, 32'h22);
        alu_op(5'd3, 32'h33);
        idle_ex();
        step();
        // Reset during RESP, with rvalid arriving afterwards
        drive_ex(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 5'd7, 32'h200, 32'h0);
        step();
        idle_ex();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
        reset = 1'b0;
        #2;
        chk("resp_stall", 32'(stall_out), 32'd1);
        step();
        reset = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'h11111111;
        #2;
        chk("late_rvalid_stall", 32'(stall_out), 32'd0);
        chk("late_rvalid_req", 32'(dmem_req), 32'd0);
        step();
        dmem_rvalid = 1'b0;
        alu_op(5'd3, 32'h5);
        idle_ex();
        repeat (3) step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
